// File: rtl/rrf.sv
// rtl/rrf.sv - rename register file: circular buffer of speculative results between dispatch and commit
// Optional feature macro: RRF_WB_BYPASS_EN (same-cycle writeback forwarding onto the four read ports)
module rrf #(
  parameter int ENT_NUM    = 64,
  parameter int ENT_SEL    = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dp_req_1,
  input  logic                  i_dp_req_2,
  output logic                  o_dp_alloc_ok,
  output logic [ENT_SEL-1:0]    o_dp_ptr_1,
  output logic [ENT_SEL-1:0]    o_dp_ptr_2,
  output logic [ENT_SEL:0]      o_free_cnt,
  input  logic [ENT_SEL-1:0]    i_rd_tag_1,
  input  logic [ENT_SEL-1:0]    i_rd_tag_2,
  input  logic [ENT_SEL-1:0]    i_rd_tag_3,
  input  logic [ENT_SEL-1:0]    i_rd_tag_4,
  output logic                  o_rd_vld_1,
  output logic                  o_rd_vld_2,
  output logic                  o_rd_vld_3,
  output logic                  o_rd_vld_4,
  output logic [DATA_WIDTH-1:0] o_rd_data_1,
  output logic [DATA_WIDTH-1:0] o_rd_data_2,
  output logic [DATA_WIDTH-1:0] o_rd_data_3,
  output logic [DATA_WIDTH-1:0] o_rd_data_4,
  input  logic                  i_wb_en_1,
  input  logic [ENT_SEL-1:0]    i_wb_tag_1,
  input  logic [DATA_WIDTH-1:0] i_wb_data_1,
  input  logic                  i_wb_en_2,
  input  logic [ENT_SEL-1:0]    i_wb_tag_2,
  input  logic [DATA_WIDTH-1:0] i_wb_data_2,
  output logic [ENT_SEL-1:0]    o_com_ptr,
  output logic                  o_com_rdy_1,
  output logic                  o_com_rdy_2,
  output logic [DATA_WIDTH-1:0] o_com_data_1,
  output logic [DATA_WIDTH-1:0] o_com_data_2,
  input  logic                  i_com_vld_1,
  input  logic                  i_com_vld_2,
  input  logic                  i_flush
);

  localparam logic [ENT_SEL-1:0] ONE_TAG = ENT_SEL'(1);
  localparam logic [ENT_SEL:0]   TWO_CNT = (ENT_SEL+1)'(2);

  logic [ENT_SEL-1:0]    alloc_ptr;
  logic [ENT_SEL-1:0]    com_ptr;
  logic [ENT_SEL-1:0]    com_ptr_next;
  logic [ENT_SEL-1:0]    com_ptr_p1;
  logic [ENT_SEL:0]      used_cnt;
  logic [ENT_NUM-1:0]    valid;
  logic [ENT_NUM-1:0]    valid_next;
  logic [DATA_WIDTH-1:0] mem [ENT_NUM];

  logic [1:0]            req_n;
  logic [1:0]            com_n;
  logic [1:0]            alloc_n;
  logic                  alloc_fire;

  logic [ENT_SEL-1:0]    rd_tag  [4];
  logic                  rd_vld  [4];
  logic [DATA_WIDTH-1:0] rd_data [4];

  // Free space is derived from the occupancy count so full (0 free) and empty (ENT_NUM free) are distinct.
  assign o_free_cnt    = (ENT_SEL+1)'(ENT_NUM) - used_cnt;
  assign req_n         = {1'b0, i_dp_req_1} + {1'b0, i_dp_req_2};
  assign o_dp_alloc_ok = (o_free_cnt >= (ENT_SEL+1)'(req_n));
  assign alloc_fire    = o_dp_alloc_ok & ~i_flush;
  assign alloc_n       = alloc_fire ? req_n : 2'd0;
  assign com_n         = {1'b0, i_com_vld_1} + {1'b0, i_com_vld_2};

  // Tags are packed without gaps: a lone slot-2 request takes the head tag.
  assign o_dp_ptr_1 = alloc_ptr;
  assign o_dp_ptr_2 = i_dp_req_1 ? alloc_ptr + ONE_TAG : alloc_ptr;

  assign com_ptr_next = com_ptr + ENT_SEL'(com_n);
  assign com_ptr_p1   = com_ptr + ONE_TAG;
  assign o_com_ptr    = com_ptr;
  assign o_com_rdy_1  = (used_cnt != '0) && valid[com_ptr];
  assign o_com_rdy_2  = (used_cnt >= TWO_CNT) && valid[com_ptr_p1];
  assign o_com_data_1 = mem[com_ptr];
  assign o_com_data_2 = mem[com_ptr_p1];

  // Pointer and occupancy update; a flush restarts allocation right after the committed entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      com_ptr   <= '0;
      used_cnt  <= '0;
    end else begin
      com_ptr <= com_ptr_next;
      if (i_flush) begin
        alloc_ptr <= com_ptr_next;
        used_cnt  <= '0;
      end else begin
        alloc_ptr <= alloc_ptr + ENT_SEL'(alloc_n);
        used_cnt  <= used_cnt + (ENT_SEL+1)'(alloc_n) - (ENT_SEL+1)'(com_n);
      end
    end
  end

  // Valid bits: writeback sets, then a fresh allocation clears, so allocation wins on a clash.
  always_comb begin
    valid_next = valid;
    if (i_wb_en_1) valid_next[i_wb_tag_1] = 1'b1;
    if (i_wb_en_2) valid_next[i_wb_tag_2] = 1'b1;
    if (alloc_fire && (i_dp_req_1 || i_dp_req_2)) valid_next[o_dp_ptr_1] = 1'b0;
    if (alloc_fire && i_dp_req_2) valid_next[o_dp_ptr_2] = 1'b0;
  end

  // Valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else        valid <= valid_next;
  end

  // Result storage is not reset; port 2 is written last so it wins on a same-tag collision.
  always_ff @(posedge clk) begin
    if (i_wb_en_1) mem[i_wb_tag_1] <= i_wb_data_1;
    if (i_wb_en_2) mem[i_wb_tag_2] <= i_wb_data_2;
  end

  assign rd_tag[0] = i_rd_tag_1;
  assign rd_tag[1] = i_rd_tag_2;
  assign rd_tag[2] = i_rd_tag_3;
  assign rd_tag[3] = i_rd_tag_4;

  // Operand reads, optionally forwarding an in-flight writeback (port 2 checked last for priority).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_vld[i]  = valid[rd_tag[i]];
      rd_data[i] = mem[rd_tag[i]];
`ifdef RRF_WB_BYPASS_EN
      if (i_wb_en_1 && (rd_tag[i] == i_wb_tag_1)) begin
        rd_vld[i]  = 1'b1;
        rd_data[i] = i_wb_data_1;
      end
      if (i_wb_en_2 && (rd_tag[i] == i_wb_tag_2)) begin
        rd_vld[i]  = 1'b1;
        rd_data[i] = i_wb_data_2;
      end
`endif
    end
  end

  assign o_rd_vld_1  = rd_vld[0];
  assign o_rd_vld_2  = rd_vld[1];
  assign o_rd_vld_3  = rd_vld[2];
  assign o_rd_vld_4  = rd_vld[3];
  assign o_rd_data_1 = rd_data[0];
  assign o_rd_data_2 = rd_data[1];
  assign o_rd_data_3 = rd_data[2];
  assign o_rd_data_4 = rd_data[3];

endmodule

// File: tb/tb_rrf.sv
// tb/tb_rrf.sv - directed self-checking bench for rrf
module tb_rrf;
  localparam int ENT_SEL = 6;
  localparam int DW      = 32;
`ifdef RRF_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic i_dp_req_1, i_dp_req_2, o_dp_alloc_ok;
  logic [ENT_SEL-1:0] o_dp_ptr_1, o_dp_ptr_2;
  logic [ENT_SEL:0] o_free_cnt;
  logic [ENT_SEL-1:0] i_rd_tag_1, i_rd_tag_2, i_rd_tag_3, i_rd_tag_4;
  logic o_rd_vld_1, o_rd_vld_2, o_rd_vld_3, o_rd_vld_4;
  logic [DW-1:0] o_rd_data_1, o_rd_data_2, o_rd_data_3, o_rd_data_4;
  logic i_wb_en_1, i_wb_en_2;
  logic [ENT_SEL-1:0] i_wb_tag_1, i_wb_tag_2;
  logic [DW-1:0] i_wb_data_1, i_wb_data_2;
  logic [ENT_SEL-1:0] o_com_ptr;
  logic o_com_rdy_1, o_com_rdy_2;
  logic [DW-1:0] o_com_data_1, o_com_data_2;
  logic i_com_vld_1, i_com_vld_2, i_flush;

  int checks = 0;
  int errors = 0;

  rrf #(.ENT_NUM(64), .ENT_SEL(ENT_SEL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dp_req_1(i_dp_req_1), .i_dp_req_2(i_dp_req_2), .o_dp_alloc_ok(o_dp_alloc_ok),
    .o_dp_ptr_1(o_dp_ptr_1), .o_dp_ptr_2(o_dp_ptr_2), .o_free_cnt(o_free_cnt),
    .i_rd_tag_1(i_rd_tag_1), .i_rd_tag_2(i_rd_tag_2), .i_rd_tag_3(i_rd_tag_3), .i_rd_tag_4(i_rd_tag_4),
    .o_rd_vld_1(o_rd_vld_1), .o_rd_vld_2(o_rd_vld_2), .o_rd_vld_3(o_rd_vld_3), .o_rd_vld_4(o_rd_vld_4),
    .o_rd_data_1(o_rd_data_1), .o_rd_data_2(o_rd_data_2), .o_rd_data_3(o_rd_data_3), .o_rd_data_4(o_rd_data_4),
    .i_wb_en_1(i_wb_en_1), .i_wb_tag_1(i_wb_tag_1), .i_wb_data_1(i_wb_data_1),
    .i_wb_en_2(i_wb_en_2), .i_wb_tag_2(i_wb_tag_2), .i_wb_data_2(i_wb_data_2),
    .o_com_ptr(o_com_ptr), .o_com_rdy_1(o_com_rdy_1), .o_com_rdy_2(o_com_rdy_2),
    .o_com_data_1(o_com_data_1), .o_com_data_2(o_com_data_2),
    .i_com_vld_1(i_com_vld_1), .i_com_vld_2(i_com_vld_2), .i_flush(i_flush)
  );

  always #5 clk = ~clk;

  task automatic idle();
    i_dp_req_1 = 0; i_dp_req_2 = 0;
    i_wb_en_1 = 0; i_wb_en_2 = 0;
    i_wb_tag_1 = '0; i_wb_tag_2 = '0; i_wb_data_1 = '0; i_wb_data_2 = '0;
    i_com_vld_1 = 0; i_com_vld_2 = 0; i_flush = 0;
    i_rd_tag_1 = '0; i_rd_tag_2 = '0; i_rd_tag_3 = '0; i_rd_tag_4 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic alloc_pairs(input int n);
    for (int k = 0; k < n; k++) begin
      i_dp_req_1 = 1; i_dp_req_2 = 1;
      @(posedge clk); #1;
    end
    i_dp_req_1 = 0; i_dp_req_2 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (o_free_cnt !== 7'd64) begin errors++; $display("FAIL reset_free got %0d exp 64", o_free_cnt); end
    checks++; if (o_dp_ptr_1 !== 6'd0) begin errors++; $display("FAIL reset_ptr1 got %0d exp 0", o_dp_ptr_1); end
    checks++; if (o_com_ptr !== 6'd0) begin errors++; $display("FAIL reset_com_ptr got %0d exp 0", o_com_ptr); end
    checks++; if ({o_com_rdy_1, o_com_rdy_2} !== 2'b00) begin errors++; $display("FAIL reset_com_rdy got %b exp 00", {o_com_rdy_1, o_com_rdy_2}); end
    checks++; if ({o_rd_vld_1, o_rd_vld_2, o_rd_vld_3, o_rd_vld_4} !== 4'b0) begin errors++; $display("FAIL reset_rd_vld got %b exp 0000", {o_rd_vld_1, o_rd_vld_2, o_rd_vld_3, o_rd_vld_4}); end
    checks++; if (o_dp_alloc_ok !== 1'b1) begin errors++; $display("FAIL reset_alloc_ok got %b exp 1", o_dp_alloc_ok); end
  endtask

  task automatic test_alloc();
    do_reset();
    i_dp_req_1 = 1; i_dp_req_2 = 1;
    @(negedge clk);
    checks++; if (o_dp_ptr_1 !== 6'd0) begin errors++; $display("FAIL alloc_ptr1 got %0d exp 0", o_dp_ptr_1); end
    checks++; if (o_dp_ptr_2 !== 6'd1) begin errors++; $display("FAIL alloc_ptr2 got %0d exp 1", o_dp_ptr_2); end
    checks++; if (o_dp_alloc_ok !== 1'b1) begin errors++; $display("FAIL alloc_ok got %b exp 1", o_dp_alloc_ok); end
    @(posedge clk); #1;
    i_dp_req_1 = 0; i_dp_req_2 = 1;
    @(negedge clk);
    checks++; if (o_dp_ptr_1 !== 6'd2) begin errors++; $display("FAIL alloc_next_ptr1 got %0d exp 2", o_dp_ptr_1); end
    checks++; if (o_free_cnt !== 7'd62) begin errors++; $display("FAIL alloc_free got %0d exp 62", o_free_cnt); end
    checks++; if (o_dp_ptr_2 !== 6'd2) begin errors++; $display("FAIL alloc_gapfree_ptr2 got %0d exp 2", o_dp_ptr_2); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (o_dp_ptr_1 !== 6'd3) begin errors++; $display("FAIL alloc_single_ptr1 got %0d exp 3", o_dp_ptr_1); end
    checks++; if (o_free_cnt !== 7'd61) begin errors++; $display("FAIL alloc_single_free got %0d exp 61", o_free_cnt); end
  endtask

  task automatic test_full();
    do_reset();
    alloc_pairs(31);
    i_dp_req_1 = 1;
    @(posedge clk); #1;
    i_dp_req_1 = 1; i_dp_req_2 = 1;
    @(negedge clk);
    checks++; if (o_dp_alloc_ok !== 1'b0) begin errors++; $display("FAIL full_two_ok got %b exp 0", o_dp_alloc_ok); end
    @(posedge clk); #1;
    i_dp_req_2 = 0;
    @(negedge clk);
    checks++; if (o_dp_ptr_1 !== 6'd63) begin errors++; $display("FAIL full_refused_ptr got %0d exp 63", o_dp_ptr_1); end
    checks++; if (o_free_cnt !== 7'd1) begin errors++; $display("FAIL full_refused_free got %0d exp 1", o_free_cnt); end
    checks++; if (o_dp_alloc_ok !== 1'b1) begin errors++; $display("FAIL full_one_ok got %b exp 1", o_dp_alloc_ok); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (o_free_cnt !== 7'd0) begin errors++; $display("FAIL full_free0 got %0d exp 0", o_free_cnt); end
    checks++; if (o_dp_alloc_ok !== 1'b0) begin errors++; $display("FAIL full_zero_ok got %b exp 0", o_dp_alloc_ok); end
    checks++; if (o_dp_ptr_1 !== 6'd0) begin errors++; $display("FAIL full_ptr_wrap got %0d exp 0", o_dp_ptr_1); end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_pairs(31);
    i_dp_req_1 = 1;
    @(posedge clk); #1;
    idle();
    for (int j = 0; j < 63; j += 2) begin
      i_wb_en_1 = 1; i_wb_tag_1 = 6'(j); i_wb_data_1 = 32'h1000 + 32'(j);
      i_wb_en_2 = (j + 1 < 63); i_wb_tag_2 = 6'(j + 1); i_wb_data_2 = 32'h1000 + 32'(j + 1);
      @(posedge clk); #1;
    end
    idle();
    for (int c = 0; c < 62; c += 2) begin
      i_com_vld_1 = 1; i_com_vld_2 = 1;
      @(negedge clk);
      checks++; if (o_com_data_1 !== 32'h1000 + 32'(c)) begin errors++; $display("FAIL wrap_com_data1[%0d] got %h exp %h", c, o_com_data_1, 32'h1000 + 32'(c)); end
      checks++; if (o_com_data_2 !== 32'h1001 + 32'(c)) begin errors++; $display("FAIL wrap_com_data2[%0d] got %h exp %h", c, o_com_data_2, 32'h1001 + 32'(c)); end
      @(posedge clk); #1;
    end
    i_com_vld_2 = 0;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (o_com_ptr !== 6'd63) begin errors++; $display("FAIL wrap_com_ptr63 got %0d exp 63", o_com_ptr); end
    checks++; if (o_free_cnt !== 7'd64) begin errors++; $display("FAIL wrap_free64 got %0d exp 64", o_free_cnt); end
    checks++; if (o_com_rdy_1 !== 1'b0) begin errors++; $display("FAIL wrap_empty_rdy got %b exp 0", o_com_rdy_1); end
    @(posedge clk); #1;
    i_dp_req_1 = 1; i_dp_req_2 = 1;
    @(negedge clk);
    checks++; if (o_dp_ptr_1 !== 6'd63) begin errors++; $display("FAIL wrap_ptr1 got %0d exp 63", o_dp_ptr_1); end
    checks++; if (o_dp_ptr_2 !== 6'd0) begin errors++; $display("FAIL wrap_ptr2 got %0d exp 0", o_dp_ptr_2); end
    @(posedge clk); #1;
    idle();
    i_wb_en_1 = 1; i_wb_tag_1 = 6'd63; i_wb_data_1 = 32'hA63;
    i_wb_en_2 = 1; i_wb_tag_2 = 6'd0;  i_wb_data_2 = 32'hA00;
    @(negedge clk);
    checks++; if ({o_com_rdy_1, o_com_rdy_2} !== 2'b00) begin errors++; $display("FAIL wrap_realloc_clear got %b exp 00", {o_com_rdy_1, o_com_rdy_2}); end
    @(posedge clk); #1;
    idle();
    i_com_vld_1 = 1; i_com_vld_2 = 1;
    @(negedge clk);
    checks++; if ({o_com_rdy_1, o_com_rdy_2} !== 2'b11) begin errors++; $display("FAIL wrap_rdy got %b exp 11", {o_com_rdy_1, o_com_rdy_2}); end
    checks++; if (o_com_data_1 !== 32'hA63) begin errors++; $display("FAIL wrap_data63 got %h exp a63", o_com_data_1); end
    checks++; if (o_com_data_2 !== 32'hA00) begin errors++; $display("FAIL wrap_data0 got %h exp a00", o_com_data_2); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (o_com_ptr !== 6'd1) begin errors++; $display("FAIL wrap_com_ptr1 got %0d exp 1", o_com_ptr); end
    checks++; if (o_free_cnt !== 7'd64) begin errors++; $display("FAIL wrap_free_after got %0d exp 64", o_free_cnt); end
  endtask

  task automatic test_writeback();
    do_reset();
    alloc_pairs(3);
    i_wb_en_1 = 1; i_wb_tag_1 = 6'd5; i_wb_data_1 = 32'hDEADBEEF;
    i_rd_tag_1 = 6'd5; i_rd_tag_2 = 6'd4;
    @(negedge clk);
    checks++; if (o_rd_vld_1 !== BYP) begin errors++; $display("FAIL wb_same_cycle_vld got %b exp %b", o_rd_vld_1, BYP); end
`ifdef RRF_WB_BYPASS_EN
    checks++; if (o_rd_data_1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_bypass_data got %h exp deadbeef", o_rd_data_1); end
`endif
    @(posedge clk); #1;
    i_wb_en_1 = 0;
    @(negedge clk);
    checks++; if (o_rd_vld_1 !== 1'b1) begin errors++; $display("FAIL wb_vld got %b exp 1", o_rd_vld_1); end
    checks++; if (o_rd_data_1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_data got %h exp deadbeef", o_rd_data_1); end
    checks++; if (o_rd_vld_2 !== 1'b0) begin errors++; $display("FAIL wb_other_vld got %b exp 0", o_rd_vld_2); end
    checks++; if (o_com_rdy_1 !== 1'b0) begin errors++; $display("FAIL wb_com_rdy got %b exp 0", o_com_rdy_1); end
    idle();
  endtask

  task automatic test_flush_commit();
    do_reset();
    alloc_pairs(2);
    i_wb_en_1 = 1; i_wb_tag_1 = 6'd0; i_wb_data_1 = 32'h11;
    i_wb_en_2 = 1; i_wb_tag_2 = 6'd1; i_wb_data_2 = 32'h22;
    @(posedge clk); #1;
    idle();
    i_com_vld_1 = 1; i_com_vld_2 = 1; i_flush = 1; i_dp_req_1 = 1; i_dp_req_2 = 1;
    @(negedge clk);
    checks++; if ({o_com_rdy_1, o_com_rdy_2} !== 2'b11) begin errors++; $display("FAIL flush_rdy got %b exp 11", {o_com_rdy_1, o_com_rdy_2}); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (o_com_ptr !== 6'd2) begin errors++; $display("FAIL flush_com_ptr got %0d exp 2", o_com_ptr); end
    checks++; if (o_dp_ptr_1 !== 6'd2) begin errors++; $display("FAIL flush_alloc_ptr got %0d exp 2", o_dp_ptr_1); end
    checks++; if (o_free_cnt !== 7'd64) begin errors++; $display("FAIL flush_free got %0d exp 64", o_free_cnt); end
  endtask

  task automatic test_same_tag();
    do_reset();
    alloc_pairs(1);
    i_wb_en_1 = 1; i_wb_tag_1 = 6'd1; i_wb_data_1 = 32'h1;
    i_wb_en_2 = 1; i_wb_tag_2 = 6'd1; i_wb_data_2 = 32'h2;
    i_rd_tag_3 = 6'd1;
`ifdef RRF_WB_BYPASS_EN
    @(negedge clk);
    checks++; if (o_rd_data_3 !== 32'h2) begin errors++; $display("FAIL same_tag_bypass got %h exp 2", o_rd_data_3); end
`endif
    @(posedge clk); #1;
    i_wb_en_1 = 0; i_wb_en_2 = 0;
    @(negedge clk);
    checks++; if (o_rd_data_3 !== 32'h2) begin errors++; $display("FAIL same_tag_data got %h exp 2", o_rd_data_3); end
    checks++; if (o_rd_vld_3 !== 1'b1) begin errors++; $display("FAIL same_tag_vld got %b exp 1", o_rd_vld_3); end
    idle();
  endtask

  task automatic test_alloc_wb_clash();
    do_reset();
    i_dp_req_1 = 1;
    i_wb_en_1 = 1; i_wb_tag_1 = 6'd0; i_wb_data_1 = 32'h55;
    @(posedge clk); #1;
    idle();
    i_rd_tag_4 = 6'd0;
    @(negedge clk);
    checks++; if (o_rd_vld_4 !== 1'b0) begin errors++; $display("FAIL clash_vld got %b exp 0", o_rd_vld_4); end
    checks++; if (o_free_cnt !== 7'd63) begin errors++; $display("FAIL clash_free got %0d exp 63", o_free_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_pairs(2);
    #2 rst_n = 0;
    #1;
    checks++; if (o_free_cnt !== 7'd64) begin errors++; $display("FAIL midrst_free got %0d exp 64", o_free_cnt); end
    checks++; if (o_dp_ptr_1 !== 6'd0) begin errors++; $display("FAIL midrst_ptr got %0d exp 0", o_dp_ptr_1); end
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_full();
    test_wrap();
    test_writeback();
    test_flush_commit();
    test_same_tag();
    test_alloc_wb_clash();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
